// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared CPU constants and the operand-fetch output state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } of_state_t;
endpackage

`default_nettype wire

// File: rtl/operand_fetch_scoreboard.sv
// ============================================================================
// Module   : operand_fetch_scoreboard
// Purpose  : Per-register pending-write vector with rs/rt/rd hazard lookups.
//            Build option RISCV_X0_ZERO_EN keeps register 0 permanently idle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_fetch_scoreboard #(
    parameter int ADDR_W = 5,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wb_clr,
    input  logic [ADDR_W-1:0] i_wb_addr,
    input  logic              i_fl_clr,
    input  logic [ADDR_W-1:0] i_fl_addr,
    input  logic              i_set,
    input  logic [ADDR_W-1:0] i_set_addr,
    input  logic [ADDR_W-1:0] i_rs_addr,
    input  logic [ADDR_W-1:0] i_rt_addr,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_rs_pend,
    output logic              o_rt_pend,
    output logic              o_rd_pend
);

    logic [NREG-1:0] r_pend;
    logic [NREG-1:0] w_pend_nxt;

    // Same-cycle writeback hides the pending bit so the hazard clears immediately.
    function automatic logic pend_eff(input logic [ADDR_W-1:0] addr);
        return r_pend[addr] & ~(i_wb_clr && (i_wb_addr == addr));
    endfunction

    assign o_rs_pend = pend_eff(i_rs_addr);
    assign o_rt_pend = pend_eff(i_rt_addr);
    assign o_rd_pend = pend_eff(i_rd_addr);

    // Clears first, then the set, so a new issue wins over a retiring write.
    always_comb begin
        w_pend_nxt = r_pend;
        if (i_fl_clr)
            w_pend_nxt[i_fl_addr] = 1'b0;
        if (i_wb_clr)
            w_pend_nxt[i_wb_addr] = 1'b0;
        if (i_set)
            w_pend_nxt[i_set_addr] = 1'b1;
`ifdef RISCV_X0_ZERO_EN
        w_pend_nxt[0] = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_pend <= '0;
        else
            r_pend <= w_pend_nxt;
    end

endmodule

`default_nettype wire

// File: rtl/operand_fetch.sv
// ============================================================================
// Module   : operand_fetch
// Purpose  : Decode-to-execute operand fetch with RAW/WAW stall, writeback
//            bypass and a valid/ready output register. Option RISCV_X0_ZERO_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_fetch #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int NREG   = cpu_pkg::NREG
) (
    input  logic              sys_clk,
    input  logic              sys_reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rs_addr,
    input  logic              in_uses_rs,
    input  logic [ADDR_W-1:0] in_rt_addr,
    input  logic              in_uses_rt,
    input  logic [ADDR_W-1:0] in_rd_addr,
    input  logic              in_rd_we,
    output logic [ADDR_W-1:0] rf_rs_addr_o,
    output logic [ADDR_W-1:0] rf_rt_addr_o,
    input  logic [DATA_W-1:0] rf_rs_data_i,
    input  logic [DATA_W-1:0] rf_rt_data_i,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rs_data,
    output logic [DATA_W-1:0] out_rt_data,
    output logic [ADDR_W-1:0] out_rd_addr,
    output logic              out_rd_we,
    output logic [31:0]       stall_cnt
);
    import cpu_pkg::*;

    of_state_t         r_state;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_rd_we;
    logic [31:0]       r_stall_cnt;

    logic w_rs_pend, w_rt_pend, w_rd_pend;
    logic w_hazard, w_accept, w_fl_clr;

    assign rf_rs_addr_o = in_rs_addr;
    assign rf_rt_addr_o = in_rt_addr;

    assign w_hazard = (in_uses_rs & w_rs_pend) | (in_uses_rt & w_rt_pend) | (in_rd_we & w_rd_pend);
    assign in_ready = ~w_hazard & ~flush & (~out_valid | out_ready);
    assign w_accept = in_valid & in_ready;
    assign w_fl_clr = flush & out_valid & r_rd_we;

    function automatic logic [DATA_W-1:0] operand(input logic [ADDR_W-1:0] addr,
                                                  input logic [DATA_W-1:0] rf_data);
`ifdef RISCV_X0_ZERO_EN
        if (addr == '0)
            return '0;
`endif
        if (wb_valid && (wb_addr == addr))
            return wb_data;
        return rf_data;
    endfunction

    operand_fetch_scoreboard #(
        .ADDR_W (ADDR_W),
        .NREG   (NREG)
    ) u_scoreboard (
        .clk        (sys_clk),
        .rst        (sys_reset),
        .i_wb_clr   (wb_valid),
        .i_wb_addr  (wb_addr),
        .i_fl_clr   (w_fl_clr),
        .i_fl_addr  (r_rd_addr),
        .i_set      (w_accept & in_rd_we),
        .i_set_addr (in_rd_addr),
        .i_rs_addr  (in_rs_addr),
        .i_rt_addr  (in_rt_addr),
        .i_rd_addr  (in_rd_addr),
        .o_rs_pend  (w_rs_pend),
        .o_rt_pend  (w_rt_pend),
        .o_rd_pend  (w_rd_pend)
    );

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            r_state   <= ST_EMPTY;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_rd_addr <= '0;
            r_rd_we   <= 1'b0;
        end else if (flush) begin
            r_state <= ST_EMPTY;
        end else if (w_accept) begin
            r_state   <= ST_FULL;
            r_rs_data <= operand(in_rs_addr, rf_rs_data_i);
            r_rt_data <= operand(in_rt_addr, rf_rt_data_i);
            r_rd_addr <= in_rd_addr;
            r_rd_we   <= in_rd_we;
        end else if (out_ready) begin
            r_state <= ST_EMPTY;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset)
            r_stall_cnt <= '0;
        else if (in_valid && !in_ready && (r_stall_cnt != 32'hFFFF_FFFF))
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign out_valid   = (r_state == ST_FULL);
    assign out_rs_data = r_rs_data;
    assign out_rt_data = r_rt_data;
    assign out_rd_addr = r_rd_addr;
    assign out_rd_we   = r_rd_we;
    assign stall_cnt   = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch.sv
// ============================================================================
// Module   : tb_operand_fetch
// Purpose  : Directed self-checking bench for operand_fetch (RISCV_X0_ZERO_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_operand_fetch;

    logic        sys_clk = 1'b0;
    logic        sys_reset;
    logic        flush, in_valid, in_ready;
    logic [4:0]  in_rs_addr, in_rt_addr, in_rd_addr;
    logic        in_uses_rs, in_uses_rt, in_rd_we;
    logic [4:0]  rf_rs_addr_o, rf_rt_addr_o;
    logic [31:0] rf_rs_data_i, rf_rt_data_i;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid, out_ready, out_rd_we;
    logic [31:0] out_rs_data, out_rt_data;
    logic [4:0]  out_rd_addr;
    logic [31:0] stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

`ifdef RISCV_X0_ZERO_EN
    localparam logic [31:0] c_X0_READ  = 32'h0;
    localparam logic [31:0] c_X0_READY = 32'd1;
`else
    localparam logic [31:0] c_X0_READ  = 32'h1234;
    localparam logic [31:0] c_X0_READY = 32'd0;
`endif

    operand_fetch dut (
        .sys_clk      (sys_clk),
        .sys_reset    (sys_reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rs_addr   (in_rs_addr),
        .in_uses_rs   (in_uses_rs),
        .in_rt_addr   (in_rt_addr),
        .in_uses_rt   (in_uses_rt),
        .in_rd_addr   (in_rd_addr),
        .in_rd_we     (in_rd_we),
        .rf_rs_addr_o (rf_rs_addr_o),
        .rf_rt_addr_o (rf_rt_addr_o),
        .rf_rs_data_i (rf_rs_data_i),
        .rf_rt_data_i (rf_rt_data_i),
        .wb_valid     (wb_valid),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_rs_data  (out_rs_data),
        .out_rt_data  (out_rt_data),
        .out_rd_addr  (out_rd_addr),
        .out_rd_we    (out_rd_we),
        .stall_cnt    (stall_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        in_uses_rs = 1'b0;
        in_uses_rt = 1'b0;
        in_rd_we   = 1'b0;
        wb_valid   = 1'b0;
        flush      = 1'b0;
    endtask

    initial begin
        sys_reset = 1'b1;
        idle();
        out_ready = 1'b1;
        in_rs_addr = '0; in_rt_addr = '0; in_rd_addr = '0;
        rf_rs_data_i = '0; rf_rt_data_i = '0;
        wb_addr = '0; wb_data = '0;
        step(); step();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        chk("rst_out_rs", out_rs_data, 32'd0);
        sys_reset = 1'b0;

        // 1: RAW stall on r5, released by same-cycle writeback with bypass
        in_valid = 1'b1; in_rd_addr = 5'd5; in_rd_we = 1'b1;
        #1 chk("t1_first_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_out_rd", {27'd0, out_rd_addr}, 32'd5);
        chk("t1_out_rd_we", {31'd0, out_rd_we}, 32'd1);
        in_rd_we = 1'b0; in_uses_rs = 1'b1; in_rs_addr = 5'd5; rf_rs_data_i = 32'h1111;
        #1 chk("t1_raw_stall", {31'd0, in_ready}, 32'd0);
        chk("t1_rf_rs_addr", {27'd0, rf_rs_addr_o}, 32'd5);
        step();
        chk("t1_stall_cnt", stall_cnt, 32'd1);
        chk("t1_drained", {31'd0, out_valid}, 32'd0);
        wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
        #1 chk("t1_wb_release", {31'd0, in_ready}, 32'd1);
        step();
        chk("t1_bypass_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_bypass_rs", out_rs_data, 32'hDEAD_BEEF);
        chk("t1_stall_hold", stall_cnt, 32'd1);
        idle();

        // 2: backpressure holds output, then back-to-back flow
        out_ready = 1'b0; in_valid = 1'b1; in_uses_rs = 1'b1; in_rs_addr = 5'd3; rf_rs_data_i = 32'hA;
        #1 chk("t2_bp_ready", {31'd0, in_ready}, 32'd0);
        step();
        chk("t2_hold_valid", {31'd0, out_valid}, 32'd1);
        chk("t2_hold_rs", out_rs_data, 32'hDEAD_BEEF);
        chk("t2_stall_cnt", stall_cnt, 32'd2);
        out_ready = 1'b1;
        #1 chk("t2_release_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("t2_b2b_rs0", out_rs_data, 32'hA);
        chk("t2_b2b_valid", {31'd0, out_valid}, 32'd1);
        in_rs_addr = 5'd4; rf_rs_data_i = 32'hB;
        in_uses_rt = 1'b1; in_rt_addr = 5'd6; rf_rt_data_i = 32'hC;
        #1 chk("t2_rf_rt_addr", {27'd0, rf_rt_addr_o}, 32'd6);
        step();
        chk("t2_b2b_rs1", out_rs_data, 32'hB);
        chk("t2_b2b_rt1", out_rt_data, 32'hC);
        idle();
        step();
        chk("t2_empty", {31'd0, out_valid}, 32'd0);

        // 3: WAW on r7
        in_valid = 1'b1; in_rd_addr = 5'd7; in_rd_we = 1'b1;
        step();
        #1 chk("t3_waw_stall", {31'd0, in_ready}, 32'd0);
        step();
        chk("t3_stall_cnt", stall_cnt, 32'd3);
        wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h0;
        #1 chk("t3_wb_release", {31'd0, in_ready}, 32'd1);
        step();
        chk("t3_out_rd", {27'd0, out_rd_addr}, 32'd7);
        wb_valid = 1'b0; in_rd_we = 1'b0; in_uses_rs = 1'b1; in_rs_addr = 5'd7;
        #1 chk("t3_repend_stall", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0; wb_valid = 1'b1; wb_addr = 5'd7;
        step();
        idle();

        // 4: flush re-opens pending bit of the held instruction; rt bypass
        out_ready = 1'b0; in_valid = 1'b1; in_rd_addr = 5'd9; in_rd_we = 1'b1;
        step();
        chk("t4_full_rd", {27'd0, out_rd_addr}, 32'd9);
        in_valid = 1'b0; in_rd_we = 1'b0; flush = 1'b1;
        #1 chk("t4_flush_ready", {31'd0, in_ready}, 32'd0);
        step();
        chk("t4_flushed", {31'd0, out_valid}, 32'd0);
        flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_uses_rs = 1'b1; in_rs_addr = 5'd9; rf_rs_data_i = 32'h99;
        #1 chk("t4_r9_free", {31'd0, in_ready}, 32'd1);
        step();
        chk("t4_rs", out_rs_data, 32'h99);
        in_uses_rs = 1'b0; in_uses_rt = 1'b1; in_rt_addr = 5'd12; rf_rt_data_i = 32'h55;
        wb_valid = 1'b1; wb_addr = 5'd12; wb_data = 32'h77;
        step();
        chk("t4_rt_bypass", out_rt_data, 32'h77);
        chk("t4_stall_cnt", stall_cnt, 32'd3);
        idle();

        // 5: register 0 handling
        in_valid = 1'b1; in_uses_rs = 1'b1; in_rs_addr = 5'd0; rf_rs_data_i = 32'h1234;
        step();
        chk("t5_x0_read", out_rs_data, c_X0_READ);
        in_uses_rs = 1'b0; in_rd_addr = 5'd0; in_rd_we = 1'b1;
        step();
        in_rd_we = 1'b0; in_uses_rs = 1'b1;
        #1 chk("t5_x0_hazard", {31'd0, in_ready}, c_X0_READY);
        in_valid = 1'b0; wb_valid = 1'b1; wb_addr = 5'd0;
        step();
        idle();

        // 6: counter saturation and asynchronous reset mid-stall
        out_ready = 1'b0; in_valid = 1'b1; in_rd_addr = 5'd20; in_rd_we = 1'b1;
        step();
        in_rd_we = 1'b0; in_uses_rs = 1'b1; in_rs_addr = 5'd20;
        force dut.r_stall_cnt = 32'hFFFF_FFFD;
        #1 release dut.r_stall_cnt;
        step(); step();
        chk("t6_saturate", stall_cnt, 32'hFFFF_FFFF);
        step();
        chk("t6_sat_hold", stall_cnt, 32'hFFFF_FFFF);
        chk("t6_pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2 sys_reset = 1'b1;
        #1;
        chk("t6_arst_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_arst_cnt", stall_cnt, 32'd0);
        chk("t6_arst_rd", {26'd0, out_rd_we, out_rd_addr}, 32'd0);
        step();
        sys_reset = 1'b0; out_ready = 1'b1;
        #1 chk("t6_pend_cleared", {31'd0, in_ready}, 32'd1);
        step();
        chk("t6_accept_after_rst", {31'd0, out_valid}, 32'd1);
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
